// File: rtl/counter.sv
// rtl/counter.sv - free-running Size-bit up-counter, wraps modulo 2^Size
// Synchronous active-high reset takes priority over the increment.
module counter #(
    parameter int Size = 5
) (
    input  logic            clock,
    input  logic            reset,
    output logic [Size-1:0] count
);

    logic [Size-1:0] count_q;
    logic [Size-1:0] count_d;

    // Truncation to Size bits provides the wrap from all-ones back to zero.
    always_comb begin
        count_d = count_q + Size'(1);
        if (reset) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - checks counter at Size 1, 5 and 8 against edge-count model
module tb_counter;

    logic       clock;
    logic       reset;
    logic [4:0] count5;
    logic [0:0] count1;
    logic [7:0] count8;

    int vectors;
    int miscompares;
    int unsigned edges_since_reset;

    typedef struct {
        logic rst;
        int   exp5;
    } vec_t;

    vec_t table_v[$];

    counter #(.Size(5)) dut5 (.clock(clock), .reset(reset), .count(count5));
    counter #(.Size(1)) dut1 (.clock(clock), .reset(reset), .count(count1));
    counter #(.Size(8)) dut8 (.clock(clock), .reset(reset), .count(count8));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // The model only knows how many edges passed since reset; every width
    // must then show that count reduced modulo its own 2^Size.
    task automatic step(input logic r);
        @(negedge clock);
        reset = r;
        @(posedge clock);
        #1;
        if (r) edges_since_reset = 0;
        else   edges_since_reset = edges_since_reset + 1;
        check("model_size5", int'(count5), int'(edges_since_reset % 32));
        check("model_size1", int'(count1), int'(edges_since_reset % 2));
        check("model_size8", int'(count8), int'(edges_since_reset % 256));
    endtask

    task automatic run_to(input int target5);
        int guard;
        guard = 0;
        while (int'(count5) != target5 && guard < 64) begin
            step(1'b0);
            guard++;
        end
        check("reach_target", int'(count5), target5);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        edges_since_reset = 0;
        reset = 1'b1;

        // Reset twice, then count 1..10.
        table_v.push_back('{rst: 1'b1, exp5: 0});
        table_v.push_back('{rst: 1'b1, exp5: 0});
        for (int i = 1; i <= 10; i++) table_v.push_back('{rst: 1'b0, exp5: i});

        foreach (table_v[i]) begin
            step(table_v[i].rst);
            check($sformatf("table[%0d]", i), int'(count5), table_v[i].exp5);
        end

        // Reset mid-count at 17.
        run_to(17);
        step(1'b1);
        check("mid_reset", int'(count5), 0);
        step(1'b0);
        check("mid_resume", int'(count5), 1);

        // Wrap at Size=5: 31 after 31 edges, 0 after 32, 1 after 33.
        step(1'b1);
        for (int i = 1; i <= 33; i++) begin
            step(1'b0);
            if (i == 31) check("wrap_31", int'(count5), 31);
            if (i == 32) check("wrap_0", int'(count5), 0);
            if (i == 33) check("wrap_1", int'(count5), 1);
        end

        // Reset at terminal value, held for three edges.
        run_to(31);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check($sformatf("term_reset[%0d]", i), int'(count5), 0);
        end

        // Size=8 reaches 255 and wraps after 256 edges; Size=1 toggles.
        for (int i = 1; i <= 256; i++) begin
            step(1'b0);
            if (i == 1)   check("size1_one", int'(count1), 1);
            if (i == 2)   check("size1_zero", int'(count1), 0);
            if (i == 255) check("size8_255", int'(count8), 255);
            if (i == 256) check("size8_wrap", int'(count8), 0);
        end

        // Random reset pattern against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
